ysyx_22050612_lsu: RTL
======================

// Module: ysyx_22050612_lsu
// PURPOSE
//  Load/store unit directly downstream of the execute stage: accepts one memory op per transaction (EXU ALU result as address),
//  runs a valid/ready request + response handshake to the data memory bus, and returns sign/zero-extended load data for GPR writeback.
//  Replaces direct combinational DPI pmem access with a multi-cycle, stallable interface. One outstanding transaction max.
// PARAMETERS
//  ADDR_W   64  byte-address width of req_addr / mem_req_addr
//  RIDX_W   5   GPR index width (rd tag carried through)
// PORTS
//  clk            in   1       clock, all state on posedge
//  rst_n          in   1       asynchronous, active-low reset
//  req_valid      in   1       EXU presents an op
//  req_ready      out  1       LSU can accept (IDLE only)
//  req_wen        in   1       1=store, 0=load
//  req_size       in   2       0=byte 1=half 2=word 3=dword
//  req_unsigned   in   1       loads: zero-extend (lbu/lhu/lwu); ignored for stores
//  req_addr       in   ADDR_W  effective byte address
//  req_wdata      in   64      store data, right-aligned (src2)
//  req_rd         in   RIDX_W  load destination register
//  mem_req_valid  out  1       bus request
//  mem_req_ready  in   1       bus accepts request
//  mem_req_wen    out  1       store
//  mem_req_addr   out  ADDR_W  req_addr with [2:0] cleared
//  mem_req_wdata  out  64      store data shifted into byte lanes
//  mem_req_wmask  out  8       byte-lane strobe (0 for loads)
//  mem_rsp_valid  in   1       bus response / write ack
//  mem_rsp_rdata  in   64      aligned 8-byte read data
//  resp_valid     out  1       one-cycle completion pulse
//  resp_wen       out  1       1 = write wb_data to GPR (loads with rd!=0, no error)
//  resp_rd        out  RIDX_W  destination tag
//  resp_data      out  64      extended load data (0 for stores)
//  resp_err       out  1       misaligned-access flag (macro only, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; mem_req_valid, resp_valid, resp_wen, resp_err=0; all data/addr/mask/rd regs 0.
//  FSM IDLE: req_ready=1; req_valid -> latch all req_* ; to REQ (to RESP with err if misaligned trap fires).
//  FSM REQ: mem_req_valid=1, outputs stable from latched regs; hold until mem_req_ready; then WAIT.
//  FSM WAIT: mem_rsp_valid -> capture extended data; to RESP. Responses in handshake cycle are not legal (bus guarantees >=1 cycle).
//  FSM RESP: resp_valid=1 for exactly one cycle, no backpressure; to IDLE. req_ready=0 in REQ/WAIT/RESP.
//  Minimum latency: accept C0, mem_req C1, rsp C2, resp_valid C3. Stores also wait for rsp (write ack).
//  Store lanes: off=addr[2:0]; wdata<<(8*off); wmask = {1,3,F,FF}[size] << off, truncated to 8 bits.
//  Load extract: rdata>>(8*off), mask to 8/16/32/64 bits, sign-extend from top bit unless req_unsigned; dword ignores req_unsigned.
//  resp_wen=0 when rd==0, for stores, or on error. mem_rsp_valid outside WAIT ignored.
//  Async reset mid-transaction: immediate return to IDLE, valids drop, in-flight bus response later ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: addr not multiple of size -> no bus transaction, IDLE->RESP, resp_err=1, resp_wen=0, resp_data=0.
//  Not defined: low addr bits below access size forced to 0 (naturally aligned access), resp_err tied 0.
// STRUCTURE
//  Package ysyx_22050612_lsu_pkg: size enum (SZ_B/H/W/D), FSM state enum (IDLE/REQ/WAIT/RESP), base wmask table constants.
//  Sub-module ysyx_22050612_lsu_align: combinational lane shift + wmask gen + load extract/extend; FSM and regs stay in top.
// TESTING
//  lb signed addr 0x80000003, rsp rdata 0x00000000_80000000 -> resp_data 0xFFFFFFFF_FFFFFF80, resp_wen=1, resp at C3.
//  sw addr 0x80000004 wdata 0x11223344 -> mem_req_addr 0x80000000, wmask 0xF0, mem_req_wdata 0x11223344_00000000, resp_wen=0.
//  lhu addr 0x80000006 rd=0, rdata 0xBEEF_0000_0000_0000 -> resp_data 0x000000000000BEEF, resp_wen=0.
//  mem_req_ready low 3 cycles -> mem_req_valid/addr/wmask held stable, req_ready=0 throughout, resp at C6.
//  lw addr 0x80000002: with LSU_MISALIGN_TRAP_EN -> no mem_req_valid, resp_err=1 at C1; without -> mem_req_addr 0x80000000, off=0.
//  rst_n low during WAIT -> next cycle IDLE, req_ready=1; late mem_rsp_valid produces no resp_valid.

Source files
------------

// File: rtl/ysyx_22050612_lsu_pkg.sv
// ysyx_22050612_lsu_pkg: shared size/state encodings and lane-mask helpers for the LSU.
package ysyx_22050612_lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [7:0] WMASK_B = 8'h01;
    localparam logic [7:0] WMASK_H = 8'h03;
    localparam logic [7:0] WMASK_W = 8'h0F;
    localparam logic [7:0] WMASK_D = 8'hFF;

    function automatic logic [7:0] base_wmask(input size_e sz);
        return sz == SZ_B ? WMASK_B : sz == SZ_H ? WMASK_H : sz == SZ_W ? WMASK_W : WMASK_D;
    endfunction

    // Address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] low_mask(input size_e sz);
        return sz == SZ_B ? 3'd0 : sz == SZ_H ? 3'd1 : sz == SZ_W ? 3'd3 : 3'd7;
    endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_align.sv
// ysyx_22050612_lsu_align: byte-lane placement of store data/strobes and load extract/extend.
// Offsets are forced to natural alignment; misaligned ops never reach here when trapping.
module ysyx_22050612_lsu_align
    import ysyx_22050612_lsu_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_ldata
);
    logic [2:0]  w_off;
    logic [5:0]  w_sh;
    logic [63:0] w_raw;
    logic        w_sx;

    assign w_off   = i_off & ~low_mask(i_size);
    assign w_sh    = {w_off, 3'b000};
    assign o_wdata = i_wdata << w_sh;
    assign o_wmask = base_wmask(i_size) << w_off;
    assign w_raw   = i_rdata >> w_sh;
    assign w_sx    = ~i_unsigned;

    always_comb begin
        o_ldata = w_raw;
        o_ldata = i_size == SZ_B ? {{56{w_sx & w_raw[7]}},  w_raw[7:0]}  :
                  i_size == SZ_H ? {{48{w_sx & w_raw[15]}}, w_raw[15:0]} :
                  i_size == SZ_W ? {{32{w_sx & w_raw[31]}}, w_raw[31:0]} : w_raw;
    end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// ysyx_22050612_lsu: single-outstanding load/store unit with valid/ready bus handshake.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned ops with resp_err instead of aligning them.
module ysyx_22050612_lsu
    import ysyx_22050612_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [RIDX_W-1:0] req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [63:0]       mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_rdata,
    output logic              resp_valid,
    output logic              resp_wen,
    output logic [RIDX_W-1:0] resp_rd,
    output logic [63:0]       resp_data,
    output logic              resp_err
);
    state_e              r_state, w_next;
    logic                r_wen, r_unsigned, r_err;
    size_e               r_size;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata, r_data;
    logic [RIDX_W-1:0]   r_rd;
    logic                w_misalign;
    logic [63:0]         w_wdata, w_ldata;
    logic [7:0]          w_wmask;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = |(req_addr[2:0] & low_mask(size_e'(req_size)));
`else
    assign w_misalign = 1'b0;
`endif

    ysyx_22050612_lsu_align u_align (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_off      (r_addr[2:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rsp_rdata),
        .o_wdata    (w_wdata),
        .o_wmask    (w_wmask),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wen      <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_wen      <= req_wen;
                r_size     <= size_e'(req_size);
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rd       <= req_rd;
                r_err      <= w_misalign;
                r_data     <= '0;
            end
            if (r_state == WAIT && mem_rsp_valid)
                r_data <= r_wen ? 64'd0 : w_ldata;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: w_next = req_valid ? (w_misalign ? RESP : REQ) : IDLE;
            REQ:  w_next = mem_req_ready ? WAIT : REQ;
            WAIT: w_next = mem_rsp_valid ? RESP : WAIT;
            RESP: w_next = IDLE;
        endcase
    end

    assign req_ready     = r_state == IDLE;
    assign mem_req_valid = r_state == REQ;
    assign mem_req_wen   = r_wen;
    assign mem_req_addr  = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_req_wdata = w_wdata;
    assign mem_req_wmask = r_wen ? w_wmask : 8'h00;
    assign resp_valid    = r_state == RESP;
    assign resp_wen      = resp_valid & ~r_wen & (|r_rd) & ~r_err;
    assign resp_rd       = r_rd;
    assign resp_data     = r_data;
    assign resp_err      = resp_valid & r_err;

endmodule
